// File: rtl/ifu_lsu_rd_arbiter.sv
// Two-master AXI-lite read arbiter: merges fetch and load/store AR channels onto one
// memory read port and steers in-order R responses back through a 1-bit routing FIFO.
module ifu_lsu_rd_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [63:0] ifu_araddr,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [1:0]  ifu_rresp,
    output logic [63:0] ifu_rdata,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [63:0] lsu_araddr,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [1:0]  lsu_rresp,
    output logic [63:0] lsu_rdata,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [63:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [1:0]  mem_rresp,
    input  logic [63:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] route_r;
    logic [CW-1:0]    wr_ptr_r;
    logic [CW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             last_grant_r;
    logic             lock_r;
    logic             lock_src_r;

    logic full_s;
    logic empty_s;
    logic req_ifu_s;
    logic req_lsu_s;
    logic has_grant_s;
    logic grant_s;
    logic head_s;
    logic ar_hs_s;
    logic r_hs_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign req_ifu_s = ifu_arvalid & ~full_s;
    assign req_lsu_s = lsu_arvalid & ~full_s;
    assign head_s    = route_r[rd_ptr_r[PW-1:0]];

    // Grant selection: a stalled offer stays locked, otherwise round-robin on ties.
    always_comb begin
        has_grant_s = 1'b0;
        grant_s     = 1'b0;
        if (lock_r) begin
            has_grant_s = 1'b1;
            grant_s     = lock_src_r;
        end else if (req_ifu_s && req_lsu_s) begin
            has_grant_s = 1'b1;
            grant_s     = ~last_grant_r;
        end else if (req_ifu_s) begin
            has_grant_s = 1'b1;
            grant_s     = 1'b0;
        end else if (req_lsu_s) begin
            has_grant_s = 1'b1;
            grant_s     = 1'b1;
        end else begin
            has_grant_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    assign mem_arvalid = has_grant_s & (grant_s ? lsu_arvalid : ifu_arvalid) & ~full_s;
    assign mem_araddr  = has_grant_s ? (grant_s ? lsu_araddr : ifu_araddr) : 64'd0;
    assign ifu_arready = has_grant_s & ~grant_s & mem_arready & ~full_s;
    assign lsu_arready = has_grant_s &  grant_s & mem_arready & ~full_s;

    assign ifu_rvalid = mem_rvalid & ~empty_s & ~head_s;
    assign lsu_rvalid = mem_rvalid & ~empty_s &  head_s;
    assign mem_rready = ~empty_s & (head_s ? lsu_rready : ifu_rready);
    assign ifu_rresp  = mem_rresp;
    assign lsu_rresp  = mem_rresp;
    assign ifu_rdata  = mem_rdata;
    assign lsu_rdata  = mem_rdata;

    assign ar_hs_s = mem_arvalid & mem_arready;
    assign r_hs_s  = mem_rvalid & mem_rready;

    // Routing FIFO, arbitration history and AR lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_r      <= {DEPTH{1'b0}};
            wr_ptr_r     <= {CW{1'b0}};
            rd_ptr_r     <= {CW{1'b0}};
            count_r      <= {CW{1'b0}};
            last_grant_r <= 1'b1;
            lock_r       <= 1'b0;
            lock_src_r   <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                route_r[wr_ptr_r[PW-1:0]] <= grant_s;
                wr_ptr_r                  <= wr_ptr_r + CW'(1);
                last_grant_r              <= grant_s;
                lock_r                    <= 1'b0;
            end else if (mem_arvalid) begin
                // Offer was not taken: pin the grant so address and valid stay stable.
                lock_r     <= 1'b1;
                lock_src_r <= grant_s;
            end
            if (r_hs_s) begin
                rd_ptr_r <= rd_ptr_r + CW'(1);
            end
            case ({ar_hs_s, r_hs_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_lsu_rd_arbiter.sv
// Randomized bench for ifu_lsu_rd_arbiter: AXI-style masters and a memory model drive
// traffic while a queue-based reference predicts every output each cycle.
module tb_ifu_lsu_rd_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [63:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [63:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [63:0] mem_araddr, mem_rdata;
    logic [1:0]  mem_rresp;

    always #5 clk = ~clk;

    ifu_lsu_rd_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rresp(mem_rresp), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Reference: issuer of every outstanding read in acceptance order, plus offer state.
    bit          m_q[$];
    bit          m_last;
    bit          m_hold;
    bit          m_hold_id;
    logic [63:0] mem_q[$];
    logic [63:0] ifu_q[$];
    logic [63:0] lsu_q[$];

    int p_ifu, p_lsu, p_mar, p_rv, p_irr, p_lrr;

    bit          e_arvalid, e_ifu_arready, e_lsu_arready;
    bit          e_ifu_rvalid, e_lsu_rvalid, e_mem_rready;
    bit          e_grant;
    logic [63:0] e_addr;

    function automatic logic [63:0] rdata_of(input logic [63:0] a);
        return a ^ 64'h9E37_79B9_7F4A_7C15;
    endfunction

    function automatic logic [1:0] rresp_of(input logic [63:0] a);
        return a[5:4];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit full, has, ri, rl;
        full = (m_q.size() == DEPTH);
        ri   = ifu_arvalid && !full;
        rl   = lsu_arvalid && !full;
        has  = 1'b1;
        if (m_hold)         e_grant = m_hold_id;
        else if (ri && rl)  e_grant = !m_last;
        else if (ri)        e_grant = 1'b0;
        else if (rl)        e_grant = 1'b1;
        else begin
            e_grant = 1'b0;
            has     = 1'b0;
        end
        e_arvalid     = has && (e_grant ? lsu_arvalid : ifu_arvalid) && !full;
        e_addr        = has ? (e_grant ? lsu_araddr : ifu_araddr) : 64'd0;
        e_ifu_arready = has && !e_grant && mem_arready && !full;
        e_lsu_arready = has &&  e_grant && mem_arready && !full;
        e_ifu_rvalid  = mem_rvalid && m_q.size() > 0 && m_q[0] == 1'b0;
        e_lsu_rvalid  = mem_rvalid && m_q.size() > 0 && m_q[0] == 1'b1;
        e_mem_rready  = m_q.size() > 0 && (m_q[0] ? lsu_rready : ifu_rready);
    endtask

    task automatic check_outputs();
        check("mem_arvalid", 64'(mem_arvalid), 64'(e_arvalid));
        check("mem_araddr", mem_araddr, e_addr);
        check("ifu_arready", 64'(ifu_arready), 64'(e_ifu_arready));
        check("lsu_arready", 64'(lsu_arready), 64'(e_lsu_arready));
        check("ifu_rvalid", 64'(ifu_rvalid), 64'(e_ifu_rvalid));
        check("lsu_rvalid", 64'(lsu_rvalid), 64'(e_lsu_rvalid));
        check("mem_rready", 64'(mem_rready), 64'(e_mem_rready));
    endtask

    task automatic cycle();
        bit          ar_hs, r_hs, ifu_rx, lsu_rx;
        logic [63:0] a, got_i, got_l;
        logic [1:0]  resp_i, resp_l;
        @(negedge clk);
        if (!ifu_arvalid && $urandom_range(99) < p_ifu) begin
            a = {$urandom(), $urandom()};
            a[63:60] = 4'h8;
            ifu_arvalid = 1'b1;
            ifu_araddr  = a;
        end
        if (!lsu_arvalid && $urandom_range(99) < p_lsu) begin
            a = {$urandom(), $urandom()};
            a[63:60] = 4'h4;
            lsu_arvalid = 1'b1;
            lsu_araddr  = a;
        end
        ifu_rready  = ($urandom_range(99) < p_irr);
        lsu_rready  = ($urandom_range(99) < p_lrr);
        mem_arready = ($urandom_range(99) < p_mar);
        if (!mem_rvalid && mem_q.size() > 0 && $urandom_range(99) < p_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata_of(mem_q[0]);
            mem_rresp  = rresp_of(mem_q[0]);
        end
        #1;
        model_eval();
        check_outputs();
        ar_hs  = e_arvalid && mem_arready;
        r_hs   = mem_rvalid && e_mem_rready;
        ifu_rx = e_ifu_rvalid && ifu_rready;
        lsu_rx = e_lsu_rvalid && lsu_rready;
        got_i  = ifu_rdata;
        got_l  = lsu_rdata;
        resp_i = ifu_rresp;
        resp_l = lsu_rresp;
        @(posedge clk);
        #1;
        if (r_hs) begin
            void'(mem_q.pop_front());
            void'(m_q.pop_front());
            mem_rvalid = 1'b0;
        end
        if (ifu_rx) begin
            a = ifu_q.pop_front();
            check("ifu_rdata", got_i, rdata_of(a));
            check("ifu_rresp", 64'(resp_i), 64'(rresp_of(a)));
        end
        if (lsu_rx) begin
            a = lsu_q.pop_front();
            check("lsu_rdata", got_l, rdata_of(a));
            check("lsu_rresp", 64'(resp_l), 64'(rresp_of(a)));
        end
        if (ar_hs) begin
            m_q.push_back(e_grant);
            m_last = e_grant;
            m_hold = 1'b0;
            mem_q.push_back(e_addr);
            if (e_grant) begin
                lsu_q.push_back(lsu_araddr);
                lsu_arvalid = 1'b0;
            end else begin
                ifu_q.push_back(ifu_araddr);
                ifu_arvalid = 1'b0;
            end
        end else if (e_arvalid) begin
            m_hold    = 1'b1;
            m_hold_id = e_grant;
        end
    endtask

    task automatic set_knobs(input int pi, input int pl, input int pm, input int pr,
                             input int ri, input int rl);
        p_ifu = pi; p_lsu = pl; p_mar = pm; p_rv = pr; p_irr = ri; p_lrr = rl;
    endtask

    task automatic model_reset();
        m_q.delete(); mem_q.delete(); ifu_q.delete(); lsu_q.delete();
        m_last = 1'b1;
        m_hold = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_arvalid"}, 64'(mem_arvalid), 64'd0);
        check({tag, "_ifu_arready"}, 64'(ifu_arready), 64'd0);
        check({tag, "_lsu_arready"}, 64'(lsu_arready), 64'd0);
        check({tag, "_mem_rready"}, 64'(mem_rready), 64'd0);
        check({tag, "_ifu_rvalid"}, 64'(ifu_rvalid), 64'd0);
        check({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'd0);
        check({tag, "_mem_araddr"}, mem_araddr, 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        ifu_arvalid = 1'b0; ifu_araddr = 64'd0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = 64'd0; lsu_rready = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rresp = 2'd0; mem_rdata = 64'd0;
        model_reset();
        set_knobs(0, 0, 100, 100, 100, 100);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Response with nothing outstanding must never be accepted.
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_0000_0001;
        #1;
        check("spurious_mem_rready", 64'(mem_rready), 64'd0);
        check("spurious_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
        mem_rvalid = 1'b0;

        // Single fetch at 0x8000_0000, response two cycles later.
        @(negedge clk);
        ifu_arvalid = 1'b1;
        ifu_araddr  = 64'h0000_0000_8000_0000;
        set_knobs(0, 0, 100, 0, 100, 100);
        cycle();
        cycle();
        set_knobs(0, 0, 100, 100, 100, 100);
        repeat (2) cycle();

        // Continuous tie: grants alternate, responses follow issue order.
        set_knobs(100, 100, 100, 100, 100, 100);
        repeat (12) cycle();

        // Lock: memory stalls AR for three cycles while both masters request.
        set_knobs(100, 100, 0, 100, 100, 100);
        repeat (3) cycle();
        set_knobs(100, 100, 100, 100, 100, 100);
        repeat (3) cycle();

        // Drain, then fill to DEPTH with IFU reads and stall the next one.
        set_knobs(0, 0, 100, 100, 100, 100);
        repeat (8) cycle();
        set_knobs(100, 0, 100, 0, 100, 100);
        repeat (DEPTH + 3) cycle();
        set_knobs(100, 0, 100, 100, 100, 100);
        repeat (4) cycle();

        // LSU response backpressure under steady push/pop traffic.
        set_knobs(0, 100, 100, 100, 100, 0);
        repeat (6) cycle();
        set_knobs(100, 100, 100, 100, 100, 100);
        repeat (10) cycle();

        // Reset with reads outstanding.
        set_knobs(100, 100, 100, 0, 100, 100);
        n = 0;
        while (m_q.size() < 3 && n < 20) begin
            cycle();
            n++;
        end
        check("outstanding_before_reset", 64'(m_q.size() >= 3), 64'd1);
        #2;
        rst_n = 1'b0;
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        mem_rvalid  = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_knobs(100, 100, 100, 100, 100, 100);
        repeat (4) cycle();

        // Randomized traffic with varying pressure.
        for (int blk = 0; blk < 30; blk++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                      $urandom_range(100), $urandom_range(100), $urandom_range(100));
            repeat (60) cycle();
        end

        // Drain everything; the arbiter must end with nothing outstanding.
        set_knobs(0, 0, 100, 100, 100, 100);
        n = 0;
        while ((m_q.size() > 0 || ifu_arvalid || lsu_arvalid) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_within_budget", 64'(n < 200), 64'd1);
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        check("drained_mem_rready", 64'(mem_rready), 64'd0);
        mem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifu_lsu_rd_arbiter.md
# ifu_lsu_rd_arbiter

Two-master AXI-lite read-channel arbiter that merges the fetch unit's read port (`ifu_*`) and the load/store unit's read port (`lsu_*`) onto the core's single memory read port (`mem_*`). It sits directly downstream of the fetch unit's AR channel and directly upstream of its R channel. It keeps up to `DEPTH` outstanding reads in flight and routes each in-order response back to the master that issued it. Write channels do not pass through this block.

## Interface
- `DEPTH`, 4: maximum number of outstanding reads, which is also the routing FIFO depth. Must be a power of two, at least 2.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ifu_arvalid`/`ifu_arready` input/output 1: fetch AR handshake.
- `ifu_araddr` input 64: fetch read address.
- `ifu_rvalid`/`ifu_rready` output/input 1: fetch R handshake.
- `ifu_rresp` output 2, `ifu_rdata` output 64: fetch response and data.
- `lsu_arvalid`/`lsu_arready` input/output 1: load AR handshake.
- `lsu_araddr` input 64: load read address.
- `lsu_rvalid`/`lsu_rready` output/input 1: load R handshake.
- `lsu_rresp` output 2, `lsu_rdata` output 64: load response and data.
- `mem_arvalid`/`mem_arready` output/input 1: memory AR handshake.
- `mem_araddr` output 64: memory read address.
- `mem_rvalid`/`mem_rready` input/output 1: memory R handshake.
- `mem_rresp` input 2, `mem_rdata` input 64: memory response and data.

## Operation
**State**
- Routing FIFO: `DEPTH` entries × 1 bit, where 0 = IFU and 1 = LSU.
- FIFO pointers and count, sized `$clog2(DEPTH)+1` bits.
- `last_grant` register, 1 bit.
- `lock` register, 1 bit.
- `lock_src` register, 1 bit.

**AR arbitration**
- Request set: `ifu_arvalid`, `lsu_arvalid`, gated by `!full`.
- While `lock`=1, the grant is `lock_src`, regardless of requests.
- Otherwise:
  - If only one master requests, grant that master.
  - If both request, grant `!last_grant` (round-robin).
- `mem_arvalid` = granted master's `arvalid` & `!full`.
- `mem_araddr` = granted master's address. Fill with 0 when there is no grant.
- The granted master's `arready` = `mem_arready` & `!full`. The other master's `arready` = 0.
- On an AR handshake (`mem_arvalid` & `mem_arready`):
  - push the grant id into the routing FIFO;
  - set `last_grant` <= grant;
  - clear `lock`.
- If `mem_arvalid` & `!mem_arready`: set `lock`<=1 and `lock_src`<=grant. This keeps the address stable and arvalid asserted until the handshake, as the AXI rule requires.
- The full condition cannot arise while `lock`=1, because count only drops while a request is waiting.

**R routing**
- The FIFO head selects the destination of the response.
- `ifu_rvalid` = `mem_rvalid` & `!empty` & (head==0).
- `lsu_rvalid` = `mem_rvalid` & `!empty` & (head==1).
- `mem_rready` = `!empty` & (head ? `lsu_rready` : `ifu_rready`).
- `rresp` and `rdata` are broadcast unchanged to both masters.
- On an R handshake (`mem_rvalid` & `mem_rready`): pop the FIFO.
- If `mem_rvalid` arrives while the FIFO is empty, it is never accepted (`mem_rready`=0). This is a slave protocol error; the block does not try to recover.

**Simultaneous events**
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- `full` is evaluated before that cycle's pop. A pop in the same cycle therefore does not enable a push when count==`DEPTH`.

**Scope exclusions**
- No flush input. The fetch unit discards stale responses itself, and the arbiter always delivers every response to its issuer.
- No reordering: responses are returned strictly in AR acceptance order.

## Timing
**Reset (async, `rst_n`=0)**
- FIFO emptied; `lock`=0; `lock_src`=0; `last_grant`=1, so the IFU wins the first tie.
- Reset values of all outputs: `mem_arvalid`=0, `ifu_arready`=0, `lsu_arready`=0, `mem_rready`=0, `ifu_rvalid`=0, `lsu_rvalid`=0, `mem_araddr`=0.
- Reset mid-transaction drops all tracking. The system resets memory together with the core.

**Latency**
- AR path: combinational, 0 cycles added.
- R path: combinational, 0 cycles added.
- Throughput: one AR and one R per cycle.

**Ordering**
- An entry is pushed at the AR handshake edge and is first visible at the head on the next cycle.
- Earliest R accepted for a request is therefore one cycle after its AR handshake.

**Capacity**
- Maximum outstanding reads = `DEPTH`.
- The (`DEPTH`+1)th AR is stalled until an R handshake has completed in an earlier cycle.

## Test plan
- **Single fetch.** Only `ifu_arvalid` with addr 0x8000_0000; `mem_arready`=1; R returns data 0x1122334455667788, resp 0 two cycles later.
  Required: `mem_araddr`=0x8000_0000; `ifu_rvalid` with that data; `lsu_rvalid` stays 0.
- **Tie round-robin.** Both masters request continuously with `mem_arready`=1.
  Required: grants alternate IFU, LSU, IFU, LSU; each R routes back to its issuer in that order.
- **Lock.** LSU wins with `mem_arready`=0 for 3 cycles while IFU also requests.
  Required: `mem_araddr` stays on the LSU address and `mem_arvalid` stays 1 until the handshake; the IFU is granted only on the next cycle.
- **Full stall.** `DEPTH`=4; 4 IFU ARs are accepted with no R.
  Required: on the 5th request `mem_arvalid`=0 and `ifu_arready`=0. After one R handshake, the 5th AR is accepted on the following cycle.
- **Simultaneous push/pop and backpressure.** Count held at 2 with one AR and one R accepted every cycle for 10 cycles; then `lsu_rready`=0 while the head entry is LSU.
  Required: count stays 2; `mem_rready`=0 until `lsu_rready` rises; no response is lost or duplicated.
- **Reset mid-run.** Assert `rst_n`=0 with 3 reads outstanding.
  Required: all valid and ready outputs are 0 immediately (asynchronous); after release the FIFO is empty and the first tie is granted to the IFU.
